// File: rtl/btb_set_assoc.sv
// Set-associative branch target buffer: 1-cycle registered lookups on NUM_PORTS ports,
// with resolved branches queued in a small FIFO and written back one entry per cycle.
module btb_set_assoc #(
    parameter int ADDR_WIDTH = 32,
    parameter int SETS       = 256,
    parameter int WAYS       = 2,
    parameter int NUM_PORTS  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_PORTS-1:0]              rd_valid,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   rd_addr,
    output logic [NUM_PORTS-1:0]              hit,
    output logic [NUM_PORTS*ADDR_WIDTH-1:0]   target,
    input  logic [NUM_PORTS-1:0]              upd_valid,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   upd_pc,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   upd_target,
    input  logic                              flush,
    output logic                              upd_stall,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - IDX - 2;
    localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int FP_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [WAYS-1:0]       valid_q [SETS];
    logic [PTR_W-1:0]      vptr_q  [SETS];
    logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
    logic [ADDR_WIDTH-1:0] tgt_q   [SETS][WAYS];

    // Queue stores the PC without its ignored byte-offset bits.
    logic [ADDR_WIDTH-3:0] fifo_pc_q  [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_tgt_q [FIFO_DEPTH];
    logic [FP_W-1:0]       head_q, tail_q, tail_nxt;
    logic [CNT_W-1:0]      count_q, push_cnt, push_amt;
    logic [FP_W-1:0]       push_slot [NUM_PORTS];

    logic [NUM_PORTS-1:0]            rd_hit;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] rd_tgt;
    logic [NUM_PORTS-1:0]            unused_lsb;

    function automatic logic [FP_W-1:0] next_ptr(input logic [FP_W-1:0] ptr);
        return (ptr == FP_W'(FIFO_DEPTH - 1)) ? '0 : ptr + FP_W'(1);
    endfunction

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [IDX-1:0]        s;
        logic [TAG_W-1:0]      t;
        logic                  h;
        logic [ADDR_WIDTH-1:0] tg;

        assign s = rd_addr[p*ADDR_WIDTH+2 +: IDX];
        assign t = rd_addr[p*ADDR_WIDTH+IDX+2 +: TAG_W];

        // Descending scan so the lowest-index matching way is the one that sticks.
        always_comb begin
            h  = 1'b0;
            tg = '0;
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (valid_q[s][PTR_W'(w)] && tag_q[s][PTR_W'(w)] == t) begin
                    h  = 1'b1;
                    tg = tgt_q[s][PTR_W'(w)];
                end
            end
        end

        assign rd_hit[p] = rd_valid[p] & h;
        assign rd_tgt[p*ADDR_WIDTH +: ADDR_WIDTH] = (rd_valid[p] && h) ? tg : '0;
        assign unused_lsb[p] = ^{rd_addr[p*ADDR_WIDTH +: 2], upd_pc[p*ADDR_WIDTH +: 2]};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hit    <= '0;
            target <= '0;
        end else begin
            hit    <= rd_hit;
            target <= rd_tgt;
        end
    end

    assign upd_stall  = (FIFO_DEPTH - int'(count_q)) < NUM_PORTS;
    assign fifo_count = count_q;

    // Accepted ports take consecutive slots in port order.
    always_comb begin
        tail_nxt = tail_q;
        push_cnt = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            push_slot[p] = tail_nxt;
            if (upd_valid[p]) begin
                tail_nxt = next_ptr(tail_nxt);
                push_cnt = push_cnt + CNT_W'(1);
            end
        end
    end

    assign push_amt = upd_stall ? '0 : push_cnt;

    logic                  drain;
    logic [ADDR_WIDTH-3:0] hd_pc;
    logic [IDX-1:0]        hd_idx;
    logic [TAG_W-1:0]      hd_tag;
    logic                  dr_hit, dr_inv;
    logic [PTR_W-1:0]      dr_hit_way, dr_inv_way, dr_way;

    assign drain  = (count_q != '0);
    assign hd_pc  = fifo_pc_q[head_q];
    assign hd_idx = hd_pc[IDX-1:0];
    assign hd_tag = hd_pc[ADDR_WIDTH-3:IDX];

    // Placement priority: matching tag, then lowest invalid way, then victim pointer.
    always_comb begin
        dr_hit     = 1'b0;
        dr_hit_way = '0;
        dr_inv     = 1'b0;
        dr_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[hd_idx][PTR_W'(w)] && tag_q[hd_idx][PTR_W'(w)] == hd_tag) begin
                dr_hit     = 1'b1;
                dr_hit_way = PTR_W'(w);
            end
            if (!valid_q[hd_idx][PTR_W'(w)]) begin
                dr_inv     = 1'b1;
                dr_inv_way = PTR_W'(w);
            end
        end
        if (dr_hit)      dr_way = dr_hit_way;
        else if (dr_inv) dr_way = dr_inv_way;
        else             dr_way = vptr_q[hd_idx];
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                vptr_q[s]  <= '0;
            end
        end else begin
            if (!upd_stall) tail_q <= tail_nxt;
            count_q <= count_q + push_amt - CNT_W'(drain);
            if (drain) begin
                head_q                 <= next_ptr(head_q);
                valid_q[hd_idx][dr_way] <= 1'b1;
                if (!dr_hit && !dr_inv)
                    vptr_q[hd_idx] <= (vptr_q[hd_idx] == PTR_W'(WAYS - 1)) ? '0
                                      : vptr_q[hd_idx] + PTR_W'(1);
            end
        end
    end

    // Payload storage carries no reset; validity is tracked by valid_q and the queue pointers.
    always_ff @(posedge clk) begin
        if (reset && !flush) begin
            if (!upd_stall) begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (upd_valid[p]) begin
                        fifo_pc_q[push_slot[p]]  <= upd_pc[p*ADDR_WIDTH+2 +: ADDR_WIDTH-2];
                        fifo_tgt_q[push_slot[p]] <= upd_target[p*ADDR_WIDTH +: ADDR_WIDTH];
                    end
                end
            end
            if (drain) begin
                tag_q[hd_idx][dr_way] <= hd_tag;
                tgt_q[hd_idx][dr_way] <= fifo_tgt_q[head_q];
            end
        end
    end
endmodule

// File: tb/tb_btb_set_assoc.sv
// Bench for btb_set_assoc: directed scenarios with literal expectations, then random
// traffic checked every cycle against a per-set table model and an update queue.
module tb_btb_set_assoc;
    localparam int AW    = 32;
    localparam int SETS  = 256;
    localparam int WAYS  = 2;
    localparam int NP    = 2;
    localparam int DEPTH = 4;
    localparam int IDX   = $clog2(SETS);

    logic                          clk = 1'b0;
    logic                          reset;
    logic [NP-1:0]                 rd_valid;
    logic [NP*AW-1:0]              rd_addr;
    logic [NP-1:0]                 hit;
    logic [NP*AW-1:0]              target;
    logic [NP-1:0]                 upd_valid;
    logic [NP*AW-1:0]              upd_pc;
    logic [NP*AW-1:0]              upd_target;
    logic                          flush;
    logic                          upd_stall;
    logic [$clog2(DEPTH+1)-1:0]    fifo_count;

    btb_set_assoc #(.ADDR_WIDTH(AW), .SETS(SETS), .WAYS(WAYS), .NUM_PORTS(NP), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .rd_valid(rd_valid), .rd_addr(rd_addr), .hit(hit),
        .target(target), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
        .flush(flush), .upd_stall(upd_stall), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit known = 0;

    // Reference model: table contents per set/way, victim pointers, pending updates.
    bit            m_valid [SETS][WAYS];
    logic [AW-1:0] m_tag   [SETS][WAYS];
    logic [AW-1:0] m_tgt   [SETS][WAYS];
    int            m_ptr   [SETS];
    logic [2*AW-1:0] exp_q[$];

    task automatic chk(input string nm, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int set_of(input logic [AW-1:0] pc);
        return int'((pc >> 2) % SETS);
    endfunction

    function automatic logic [AW-1:0] tag_of(input logic [AW-1:0] pc);
        return pc >> (IDX + 2);
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 0;
        end
        exp_q.delete();
    endfunction

    function automatic void model_lookup(input logic [AW-1:0] pc, output bit h, output logic [AW-1:0] t);
        int s = set_of(pc);
        h = 0;
        t = '0;
        for (int w = 0; w < WAYS; w++)
            if (!h && m_valid[s][w] && m_tag[s][w] == tag_of(pc)) begin
                h = 1;
                t = m_tgt[s][w];
            end
    endfunction

    function automatic void model_place(input logic [AW-1:0] pc, input logic [AW-1:0] tgt);
        int s = set_of(pc);
        int way = -1;
        for (int w = 0; w < WAYS; w++)
            if (way < 0 && m_valid[s][w] && m_tag[s][w] == tag_of(pc)) way = w;
        for (int w = 0; w < WAYS; w++)
            if (way < 0 && !m_valid[s][w]) way = w;
        if (way < 0) begin
            way = m_ptr[s];
            m_ptr[s] = (m_ptr[s] + 1) % WAYS;
        end
        m_valid[s][way] = 1;
        m_tag[s][way]   = tag_of(pc);
        m_tgt[s][way]   = tgt;
    endfunction

    task automatic idle();
        reset = 1'b1; flush = 1'b0;
        rd_valid = '0; rd_addr = '0;
        upd_valid = '0; upd_pc = '0; upd_target = '0;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_valid[p] = 1'b1;
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic set_upd(input int p, input logic [AW-1:0] pc, input logic [AW-1:0] tg);
        upd_valid[p] = 1'b1;
        upd_pc[p*AW +: AW] = pc;
        upd_target[p*AW +: AW] = tg;
    endtask

    // One clock: check pre-edge occupancy/stall, advance the model, check registered lookups.
    task automatic step();
        bit            estall;
        bit            eh [NP];
        logic [AW-1:0] et [NP];
        logic [2*AW-1:0] e;
        estall = 0;
        if (known) begin
            estall = (DEPTH - exp_q.size()) < NP;
            chk("upd_stall", upd_stall, estall);
            chk("fifo_count", fifo_count, exp_q.size());
        end
        for (int p = 0; p < NP; p++) begin
            eh[p] = 0;
            et[p] = '0;
            if (reset && rd_valid[p]) model_lookup(rd_addr[p*AW +: AW], eh[p], et[p]);
        end
        if (!reset) begin
            model_clear();
            known = 1;
        end else if (known) begin
            if (flush) model_clear();
            else begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    model_place(e[2*AW-1:AW], e[AW-1:0]);
                end
                if (!estall)
                    for (int p = 0; p < NP; p++)
                        if (upd_valid[p]) exp_q.push_back({upd_pc[p*AW +: AW], upd_target[p*AW +: AW]});
            end
        end
        @(posedge clk);
        #1;
        if (known)
            for (int p = 0; p < NP; p++) begin
                chk($sformatf("hit%0d", p), hit[p], eh[p]);
                chk($sformatf("target%0d", p), target[p*AW +: AW], et[p]);
            end
    endtask

    task automatic reset_pulse();
        idle();
        reset = 1'b0;
        step();
        idle();
    endtask

    initial begin
        int cnt_exp[3] = '{0, 2, 3};
        logic [AW-1:0] pc;
        idle();
        reset = 1'b0;
        step();
        step();
        idle();

        // Basic push-drain-lookup latency.
        set_upd(0, 32'h1004, 32'h2000); step();
        idle(); step();
        set_rd(0, 32'h1004); step();
        chk("t036_hit", hit[0], 1);
        chk("t036_tgt", target[0 +: AW], 32'h2000);
        idle();

        // Three PCs in set 1 with two ways: the first one is evicted.
        reset_pulse();
        set_upd(0, 32'h1004, 32'hA000); set_upd(1, 32'h2004, 32'hB000); step();
        idle(); set_upd(0, 32'h3004, 32'hC000); step();
        idle(); step(); step();
        set_rd(0, 32'h1004); set_rd(1, 32'h2004); step();
        chk("t037_miss1004", hit[0], 0);
        chk("t037_hit2004", hit[1], 1);
        chk("t037_tgt2004", target[AW +: AW], 32'hB000);
        idle(); set_rd(0, 32'h3004); step();
        chk("t037_hit3004", hit[0], 1);
        chk("t037_tgt3004", target[0 +: AW], 32'hC000);
        chk("t037_model_ptr", m_ptr[1], 1);
        idle();

        // Lookup in the same cycle as the drain write sees the old contents.
        reset_pulse();
        set_upd(0, 32'h1004, 32'h2000); step();
        idle(); set_rd(0, 32'h1004); step();
        chk("t038_same_cycle", hit[0], 0);
        step();
        chk("t038_next_cycle", hit[0], 1);
        idle();

        // Queue fill with two pushes per cycle; the third pair is dropped.
        reset_pulse();
        for (int i = 0; i < 3; i++) begin
            set_upd(0, 32'h1008 + i * 32'h2000, 32'h100 + i);
            set_upd(1, 32'h2008 + i * 32'h2000, 32'h200 + i);
            chk("t039_count", fifo_count, cnt_exp[i]);
            if (i == 2) chk("t039_stall", upd_stall, 1);
            step();
        end
        idle(); step(); step(); step();
        set_rd(0, 32'h5008); set_rd(1, 32'h4008); step();
        chk("t039_dropped", hit[0], 0);
        chk("t039_kept", hit[1], 1);
        idle();

        // Flush with pushes pending.
        reset_pulse();
        set_upd(0, 32'h1004, 32'h11); set_upd(1, 32'h2004, 32'h22); step();
        idle(); step(); step();
        set_upd(0, 32'h3004, 32'h33); set_upd(1, 32'h4004, 32'h44); flush = 1'b1; step();
        idle();
        chk("t040_count", fifo_count, 0);
        chk("t040_stall", upd_stall, 0);
        set_rd(0, 32'h1004); set_rd(1, 32'h2004); step();
        chk("t040_miss0", hit[0], 0);
        chk("t040_miss1", hit[1], 0);
        idle();

        // Reset with three entries queued.
        reset_pulse();
        set_upd(0, 32'h1010, 32'h1); set_upd(1, 32'h2010, 32'h2); step();
        set_upd(0, 32'h3010, 32'h3); set_upd(1, 32'h4010, 32'h4); step();
        idle();
        chk("t041_queued", fifo_count, 3);
        reset = 1'b0; set_rd(0, 32'h1010); step();
        chk("t041_count", fifo_count, 0);
        chk("t041_hit", hit[0], 0);
        idle();
        chk("t041_stall", upd_stall, 0);
        set_rd(0, 32'h1010); set_rd(1, 32'h2010); step();
        chk("t041_miss1010", hit[0], 0);
        chk("t041_miss2010", hit[1], 0);
        set_rd(0, 32'h3010); set_rd(1, 32'h4010); step();
        chk("t041_miss3010", hit[0], 0);
        chk("t041_miss4010", hit[1], 0);
        idle();

        // Random traffic over a few sets and tags so hits, refills and evictions all occur.
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 99) != 0);
            flush = ($urandom_range(0, 39) == 0);
            for (int p = 0; p < NP; p++) begin
                rd_valid[p] = $urandom_range(0, 3) != 0;
                pc = (AW'($urandom_range(0, 5)) << (IDX + 2)) | (AW'($urandom_range(0, 3)) << 2)
                     | AW'($urandom_range(0, 3));
                rd_addr[p*AW +: AW] = pc;
                upd_valid[p] = $urandom_range(0, 1);
                pc = (AW'($urandom_range(0, 5)) << (IDX + 2)) | (AW'($urandom_range(0, 3)) << 2)
                     | AW'($urandom_range(0, 3));
                upd_pc[p*AW +: AW] = pc;
                upd_target[p*AW +: AW] = $urandom;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/btb_set_assoc.md
BTB_SET_ASSOC -- requirements
Module: btb_set_assoc

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, sets PC/target width in bits.
REQ-002 Parameter SETS, default 256, sets the number of sets; power of two, at least 2.
REQ-003 Parameter WAYS, default 2, sets associativity; power of two, 1..8.
REQ-004 Parameter NUM_PORTS, default 2, sets the number of lookup ports and the number of update ports.
REQ-005 Parameter FIFO_DEPTH, default 4, sets update-queue entries; at least NUM_PORTS.
REQ-006 clk  in  1  single clock; all state updates on posedge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 rd_valid  in  [NUM_PORTS]x1  lookup request per port.
REQ-009 rd_addr  in  [NUM_PORTS]xADDR_WIDTH  lookup PC per port.
REQ-010 hit  out  [NUM_PORTS]x1  registered lookup hit.
REQ-011 target  out  [NUM_PORTS]xADDR_WIDTH  registered predicted target.
REQ-012 upd_valid  in  [NUM_PORTS]x1  resolved taken branch to record.
REQ-013 upd_pc / upd_target  in  [NUM_PORTS]xADDR_WIDTH each  branch PC and its target.
REQ-014 flush  in  1  invalidate the whole table and drop queued updates.
REQ-015 upd_stall  out  1  update queue cannot accept NUM_PORTS pushes this cycle.
REQ-016 fifo_count  out  $clog2(FIFO_DEPTH+1)  current update-queue occupancy.

Function
REQ-017 Index field is addr[IDX+1:2] with IDX=$clog2(SETS); tag field is addr[ADDR_WIDTH-1:IDX+2]; addr[1:0] is ignored.
REQ-018 Each way holds a valid bit, a tag and a target; each set holds a $clog2(WAYS)-bit victim pointer (0 when WAYS=1).
REQ-019 Lookup latency is 1 cycle: a request at cycle N produces hit/target at cycle N+1.
REQ-020 hit = rd_valid & (any way in the set is valid with a matching tag); target is that way's target, else 0.
REQ-021 Multiple matching ways never occur by construction; the lowest-index matching way wins if they do.
REQ-022 Lookups read array state before the same-cycle drain write (read-before-write) and never see entries still queued.
REQ-023 Push: when upd_stall=0, every port with upd_valid=1 is enqueued that cycle, in port order 0..NUM_PORTS-1.
REQ-024 Push: when upd_stall=1, all upd_valid are dropped; the producer must hold them.
REQ-025 upd_stall = (FIFO_DEPTH - fifo_count) < NUM_PORTS; it is combinational from registered occupancy.
REQ-026 Drain: the head entry, if one exists, is written to the arrays each cycle, so an entry pushed at N is written at N+1 at the earliest.
REQ-027 Drain and push happen in the same cycle; occupancy = count + pushes - drain, and wrap-around of the circular pointers is modulo FIFO_DEPTH.
REQ-028 Drain placement follows the first applicable rule:
  - tag hit in the set: overwrite that way's target, pointer unchanged;
  - else an invalid way exists: fill the lowest-index invalid way, pointer unchanged;
  - else: replace the way at the victim pointer, then increment the pointer modulo WAYS.
REQ-029 Lookups do not modify victim pointers.
REQ-030 flush=1: next cycle all valid bits=0, pointers=0, queue empty, and this cycle's push and drain are discarded.
REQ-031 flush has no effect on hit/target registered in the same cycle.

Reset
REQ-032 reset=0 at posedge clears all valid bits, victim pointers, queue pointers and fifo_count, and forces hit=0 and target=0.
REQ-033 Tag/target storage is not reset.
REQ-034 Reset mid-operation discards queued updates; upd_stall=0 in the first cycle after reset is released.
REQ-035 Reset has priority over flush, push and drain.

Verification
REQ-036 Defaults: push upd_pc=0x00001004, upd_target=0x00002000 at cycle N, then rd_addr=0x00001004 at N+2 -> hit=1, target=0x00002000 at N+3.
REQ-037 Defaults: updates 0x1004, 0x2004, 0x3004 (all set 1) drained in order, then lookups -> 0x1004 miss, 0x2004 hit, 0x3004 hit; set-1 pointer=1.
REQ-038 Same-cycle read of 0x1004 and drain of 0x1004 -> hit=0 that cycle; the same read one cycle later -> hit=1.
REQ-039 FIFO_DEPTH=4: push 2 per cycle for 3 cycles -> fifo_count 0,2,3 and upd_stall=1 at count 3; the third pair is dropped.
REQ-040 Fill a set, then flush=1 with upd_valid=1 -> next cycle fifo_count=0 and all lookups hit=0.
REQ-041 Assert reset=0 with 3 entries queued -> fifo_count=0, hit=0, and the prior PCs miss after reset is released.
